// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: CPOL/CPHA modes, runtime length, MSB/LSB-first,
// N active-low selects and a programmable SCK half-period, all registered on CLOCK.
module spi_master_param #(
  parameter int DATA_W = 64,
  parameter int N_SS   = 4,
  parameter int LEN_W  = 7,
  parameter int DIV_W  = 8,
  localparam int SEL_W = (N_SS > 1) ? $clog2(N_SS) : 1
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic              start,
  output logic              ready,
  output logic              busy,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [LEN_W-1:0]  length,
  input  logic [SEL_W-1:0]  slave_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  divider,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic [N_SS-1:0]   SS
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_e;

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);
  localparam logic [LEN_W:0]   EDGE_ONE = (LEN_W+1)'(1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
  logic [LEN_W:0]      edge_q, edge_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                sck_q, sck_d, mosi_q, mosi_d;
  logic [N_SS-1:0]     ss_q, ss_d, ss_sel;

  logic [LEN_W-1:0]    len_eff, pad_in, pad_q;
  logic [DATA_W-1:0]   tx_aligned;
  logic [LEN_W:0]      edge_next, last_edge;
  logic                do_accept, do_edge, leading, sample, drive;

  // MSB-first data is pre-shifted so bit L-1 sits at the top of the shift register.
  always_comb begin
    len_eff    = ((length == '0) || (length > LEN_MAX)) ? LEN_MAX : length;
    pad_in     = LEN_MAX - len_eff;
    pad_q      = LEN_MAX - len_q;
    tx_aligned = tx_data << pad_in;
    edge_next  = edge_q + EDGE_ONE;
    last_edge  = {len_q, 1'b0};
    leading    = edge_next[0];
    ss_sel     = '1;
    for (int i = 0; i < N_SS; i++) begin
      if (slave_sel == SEL_W'(i)) ss_sel[i] = 1'b0;
    end
  end

  // NOTE: every next-state signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_d     = edge_q;
    len_d      = len_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    do_accept  = 1'b0;
    do_edge    = 1'b0;
    sample     = 1'b0;
    drive      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        sck_d     = cpol;
        do_accept = start;
      end
      S_SETUP, S_SHIFT: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          do_edge = 1'b1;
          state_d = (edge_next == last_edge) ? S_HOLD : S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q == div_q) begin
          cnt_d      = '0;
          state_d    = S_DONE;
          rx_valid_d = 1'b1;
          rx_data_d  = lsb_q ? (rx_sh_q >> pad_q) : rx_sh_q;
          ss_d       = '1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        sck_d     = cpol;
        do_accept = start;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_edge) begin
      sck_d  = ~sck_q;
      edge_d = edge_next;
      sample = cpha_q ? ~leading : leading;
      // cpha=1 already presents bit 0 from SETUP; cpha=0 holds the last bit at the final edge.
      drive  = cpha_q ? (leading && (edge_next != EDGE_ONE))
                      : (!leading && (edge_next != last_edge));
      if (sample) begin
        rx_sh_d = lsb_q ? {MISO, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], MISO};
      end
      if (drive) begin
        tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
        mosi_d  = lsb_q ? tx_sh_q[1] : tx_sh_q[DATA_W-2];
      end
    end

    if (do_accept) begin
      state_d = S_SETUP;
      cnt_d   = '0;
      edge_d  = '0;
      div_d   = divider;
      len_d   = len_eff;
      cpha_d  = cpha;
      lsb_d   = lsb_first;
      tx_sh_d = lsb_first ? tx_data : tx_aligned;
      mosi_d  = lsb_first ? tx_data[0] : tx_aligned[DATA_W-1];
      rx_sh_d = '0;
      ss_d    = ss_sel;
      sck_d   = cpol;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      len_q      <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      len_q      <= len_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
    end
  end

  assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy     = ~ready;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign MOSI     = mosi_q;
  assign SCK      = sck_q;
  assign SS       = ss_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Randomised scoreboard bench for spi_master_param: a behavioural slave and a
// per-cycle pin model derived from edge timing; rx results are checked on rx_valid.
`timescale 1ns/1ps
module tb_spi_master_param;

  logic        CLOCK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [63:0] tx_data = '0;
  logic [6:0]  length = '0;
  logic [1:0]  slave_sel = '0;
  logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0]  divider = '0;
  logic        MISO;
  logic        ready, busy, rx_valid, MOSI, SCK;
  logic [63:0] rx_data;
  logic [3:0]  SS;

  spi_master_param #(.DATA_W(64), .N_SS(4), .LEN_W(7), .DIV_W(8)) dut (
    .CLOCK(CLOCK), .RST(RST), .start(start), .ready(ready), .busy(busy),
    .tx_data(tx_data), .length(length), .slave_sel(slave_sel), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb_first), .divider(divider), .rx_data(rx_data),
    .rx_valid(rx_valid), .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .SS(SS)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge CLOCK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the transfer in progress.
  int          m_L = 1, m_H = 1, m_E = 0;
  logic        m_cpol = 0, m_cpha = 0, m_lsb = 0, m_loop = 0;
  logic [63:0] m_tx = '0, m_slave = '0;
  logic [3:0]  m_ss = 4'hF;
  bit          active = 0;
  int          edge_cnt = 0;

  typedef struct { logic [63:0] rx; int cyc; } exp_t;
  exp_t sb[$];

  // Bit position on the wire after `edges` SCK edges: the data bit currently being exchanged.
  function automatic int bit_pos(int edges, logic ph, logic lsb, int L);
    int idx;
    idx = ph ? (((edges + 1) / 2 == 0) ? 0 : (edges + 1) / 2 - 1) : edges / 2;
    if (idx > L - 1) idx = L - 1;
    return lsb ? idx : L - 1 - idx;
  endfunction

  always @(SCK) if (active) edge_cnt++;

  assign MISO = m_loop ? MOSI : m_slave[bit_pos(edge_cnt, m_cpha, m_lsb, m_L)];

  // Monitor: pops the scoreboard on rx_valid, otherwise checks pins against the timing model.
  always @(negedge CLOCK) begin : monitor
    int   m, k;
    exp_t e;
    if (!RST) begin
      if (rx_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rx_valid", 64'(rx_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rx_data", rx_data, e.rx);
          check("rx_valid_cycle", 64'(cyc), 64'(e.cyc));
          check("sck_edge_count", 64'(edge_cnt), 64'(2 * m_L));
          check("ss_in_done", 64'(SS), 64'hF);
          check("ready_in_done", 64'(ready), 64'd1);
        end
        active = 0;
      end else if (active) begin
        m = cyc - m_E + 1;
        k = (m - 1) / m_H;
        if (k > 2 * m_L) k = 2 * m_L;
        check("sck_level", 64'(SCK), 64'(m_cpol ^ k[0]));
        check("ss_level", 64'(SS), 64'(m_ss));
        check("mosi_bit", 64'(MOSI), 64'(m_tx[bit_pos(k, m_cpha, m_lsb, m_L)]));
        check("busy_during_xfer", {62'd0, ready, busy}, 64'd1);
      end
    end
  end

  task automatic do_xfer(input logic [63:0] tx, input logic [6:0] len, input logic [1:0] sel,
                         input logic cp, input logic ph, input logic lsb, input logic [7:0] div,
                         input logic loop, input logic [63:0] slv);
    int          L;
    logic [63:0] mask;
    check("ready_before_start", 64'(ready), 64'd1);
    tx_data = tx; length = len; slave_sel = sel; cpol = cp; cpha = ph;
    lsb_first = lsb; divider = div; start = 1'b1;
    @(posedge CLOCK);
    #1;
    start = 1'b0;
    L = (len == 0 || len > 64) ? 64 : int'(len);
    m_L = L; m_H = int'(div) + 1; m_E = cyc; m_cpol = cp; m_cpha = ph; m_lsb = lsb;
    m_tx = tx; m_slave = slv; m_loop = loop; m_ss = ~(4'b0001 << sel);
    mask = (L == 64) ? {64{1'b1}} : ((64'd1 << L) - 64'd1);
    sb.push_back('{rx: (loop ? tx : slv) & mask, cyc: cyc + (2 * L + 1) * m_H});
    edge_cnt = 0;
    active   = 1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000 && active; i++) @(negedge CLOCK);
    check("xfer_timeout", 64'(active), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    // Reset state
    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rx_valid", 64'(rx_valid), 64'd0);
    check("rst_rx_data", rx_data, 64'd0);
    check("rst_mosi", 64'(MOSI), 64'd0);
    check("rst_sck", 64'(SCK), 64'd0);
    check("rst_ss", 64'(SS), 64'hF);
    @(negedge CLOCK); RST = 1'b0;
    cpol = 1'b1;
    @(negedge CLOCK);
    check("idle_sck_follows_cpol", 64'(SCK), 64'd1);
    cpol = 1'b0;
    @(negedge CLOCK);

    // Mode 0, MSB-first, L=8, fastest SCK, loopback on slave 2
    do_xfer(64'hA5, 7'd8, 2'd2, 0, 0, 0, 8'd0, 1, '0);
    wait_idle();
    // Mode 3, H=4, L=16, slave returns 0xBEEF
    do_xfer(64'h1234, 7'd16, 2'd0, 1, 1, 0, 8'd3, 0, 64'hBEEF);
    wait_idle();
    // LSB-first, length 0 means full width, mode 1 loopback
    do_xfer(64'h0123456789ABCDEF, 7'd0, 2'd3, 0, 1, 1, 8'd1, 1, '0);
    wait_idle();
    // Oversized length clamps to full width, mode 2
    do_xfer(64'hFEDCBA9876543210, 7'd100, 2'd1, 1, 0, 0, 8'd0, 0, 64'h5555AAAA3333CCCC);
    wait_idle();

    // Reset in the middle of a transfer
    do_xfer(64'hC3, 7'd8, 2'd1, 0, 0, 0, 8'd0, 1, '0);
    repeat (9) @(posedge CLOCK);
    #1;
    active = 0;
    void'(sb.pop_back());
    RST = 1'b1;
    #1;
    check("abort_ss", 64'(SS), 64'hF);
    check("abort_sck", 64'(SCK), 64'd0);
    check("abort_mosi", 64'(MOSI), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    repeat (3) @(negedge CLOCK);
    RST = 1'b0;
    repeat (20) @(negedge CLOCK);
    do_xfer(64'h69, 7'd8, 2'd1, 0, 0, 0, 8'd0, 1, '0);
    wait_idle();

    // Back-to-back: restart in the rx_valid cycle
    do_xfer(64'h96, 7'd8, 2'd1, 0, 0, 0, 8'd1, 1, '0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK);
      if (rx_valid) begin found = 1; break; end
    end
    check("b2b_first_done", 64'(found), 64'd1);
    check("b2b_ss_gap", 64'(SS), 64'hF);
    do_xfer(64'h3C, 7'd4, 2'd1, 0, 0, 0, 8'd1, 1, '0);
    wait_idle();

    // Inputs toggled mid-transfer must not disturb it; stray starts are dropped
    do_xfer(64'h5A, 7'd8, 2'd0, 0, 0, 0, 8'd1, 1, '0);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLOCK);
      cpol = 1'($urandom); tx_data = {$urandom, $urandom}; start = 1'($urandom);
    end
    @(negedge CLOCK);
    start = 1'b0; cpol = 1'b0;
    wait_idle();

    // Randomised transfers
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLOCK);
      do_xfer({$urandom, $urandom}, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)),
              1'($urandom), {$urandom, $urandom});
      wait_idle();
    end

    repeat (5) @(negedge CLOCK);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
